// File: rtl/seg_pair_scanner_pkg.sv
// Shared types and constants for the two-digit segment scanner.
// Imported by the scanner top and its dwell/gap counter.
package seg_pair_scanner_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHOW_LO,
        GAP_LO,
        SHOW_HI,
        GAP_HI
    } state_t;

    localparam logic [6:0] ZERO_PAT_DEF = 7'b1000000;

    localparam logic [1:0] DIG_NONE = 2'b00;
    localparam logic [1:0] DIG_LO   = 2'b01;
    localparam logic [1:0] DIG_HI   = 2'b10;

    function automatic logic [6:0] seg_off(input bit act_low);
        return act_low ? 7'h7F : 7'h00;
    endfunction

endpackage

// File: rtl/seg_pair_scanner_counter.sv
// Dwell/gap counter: restarts at zero on every state change, holds when idle,
// flags the terminal count of the current state's duration.
module seg_dwell_counter #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] limit,
    output logic          done,
    output logic [CW-1:0] cnt_nxt
);

    logic [CW-1:0] cnt;

    always_comb begin
        cnt_nxt = cnt;
        if (load)
            cnt_nxt = '0;
        else if (en)
            cnt_nxt = cnt + CW'(1);
    end

    assign done = (cnt == limit - CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

endmodule

// File: rtl/seg_pair_scanner.sv
// Time-multiplexes a two-digit segment word onto one shared segment bus
// with dark anti-ghosting gaps and optional leading-zero blanking.
module seg_pair_scanner
    import seg_pair_scanner_pkg::*;
#(
    parameter int         DWELL_CYC   = 16,
    parameter int         GAP_CYC     = 2,
    parameter bit         SEG_ACT_LOW = 1'b1,
    parameter logic [6:0] ZERO_PAT    = ZERO_PAT_DEF,
    parameter bit         BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [13:0] i_seg,
    output logic        o_ready,
    output logic [6:0]  o_seg,
    output logic [1:0]  o_dig,
    output logic        o_frame
);

    localparam logic [6:0] SEG_OFF = seg_off(SEG_ACT_LOW);
    localparam int CMAX = (DWELL_CYC > GAP_CYC) ? DWELL_CYC : GAP_CYC;
    localparam int CW = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] DWELL_L = CW'(DWELL_CYC);
    localparam logic [CW-1:0] GAP_L   = CW'(GAP_CYC);

    state_t        state, nxt;
    logic [13:0]   held, held_n;
    logic          xfer, done, load, en;
    logic [CW-1:0] limit, cnt_nxt;
    logic [6:0]    seg_n;
    logic [1:0]    dig_n;
    logic          rdy_n, frame_n;

    assign xfer   = i_valid & o_ready;
    assign held_n = xfer ? i_seg : held;
    assign load   = (nxt != state);
    assign en     = (state != IDLE);
    assign limit  = (state == SHOW_LO || state == SHOW_HI) ? DWELL_L : GAP_L;

    seg_dwell_counter #(.CW(CW)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .en      (en),
        .limit   (limit),
        .done    (done),
        .cnt_nxt (cnt_nxt)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (xfer) nxt = SHOW_LO;
            SHOW_LO: if (done) nxt = GAP_LO;
            GAP_LO:  if (done) nxt = SHOW_HI;
            SHOW_HI: if (done) nxt = GAP_HI;
            GAP_HI:  if (done) nxt = SHOW_LO;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they stay registered Moore.
    always_comb begin
        seg_n   = SEG_OFF;
        dig_n   = DIG_NONE;
        rdy_n   = 1'b1;
        frame_n = 1'b0;
        unique case (nxt)
            SHOW_LO: begin
                rdy_n = 1'b0;
                dig_n = DIG_LO;
                seg_n = held_n[6:0];
            end
            SHOW_HI: begin
                rdy_n = 1'b0;
                if (!(BLANK_LZ && held_n[13:7] == ZERO_PAT)) begin
                    dig_n = DIG_HI;
                    seg_n = held_n[13:7];
                end
            end
            GAP_HI:  frame_n = (cnt_nxt == GAP_L - CW'(1));
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            held    <= {SEG_OFF, SEG_OFF};
            o_seg   <= SEG_OFF;
            o_dig   <= DIG_NONE;
            o_ready <= 1'b1;
            o_frame <= 1'b0;
        end else begin
            state   <= nxt;
            held    <= held_n;
            o_seg   <= seg_n;
            o_dig   <= dig_n;
            o_ready <= rdy_n;
            o_frame <= frame_n;
        end
    end

endmodule

// File: tb/tb_seg_pair_scanner.sv
// Directed and randomized checks of the segment pair scanner
// with DWELL_CYC = 4, GAP_CYC = 1 (10-cycle frame).
module tb_seg_pair_scanner;

    localparam logic [6:0] ZP = 7'b1000000;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [13:0] i_seg;
    logic        o_ready;
    logic [6:0]  o_seg;
    logic [1:0]  o_dig;
    logic        o_frame;

    int tests;
    int fails;

    seg_pair_scanner #(
        .DWELL_CYC   (4),
        .GAP_CYC     (1),
        .SEG_ACT_LOW (1'b1),
        .ZERO_PAT    (ZP),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_seg   (i_seg),
        .o_ready (o_ready),
        .o_seg   (o_seg),
        .o_dig   (o_dig),
        .o_frame (o_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [6:0] es,
                           input logic [1:0] ed, input logic er,
                           input logic ef);
        chk({tag, "_seg"}, 16'(o_seg), 16'(es));
        chk({tag, "_dig"}, 16'(o_dig), 16'(ed));
        chk({tag, "_rdy"}, 16'(o_ready), 16'(er));
        chk({tag, "_frm"}, 16'(o_frame), 16'(ef));
    endtask

    task automatic chk_dark(input string tag);
        chk_out(tag, 7'h7F, 2'b00, 1'b1, 1'b0);
    endtask

    // Expected outputs at position pos (0..9) of a frame showing word w.
    task automatic chk_pos(input string tag, input int pos,
                           input logic [13:0] w);
        logic [6:0] es;
        logic [1:0] ed;
        logic       er;
        logic       ef;
        es = 7'h7F;
        ed = 2'b00;
        er = 1'b1;
        ef = 1'b0;
        if (pos < 4) begin
            ed = 2'b01;
            es = w[6:0];
            er = 1'b0;
        end else if (pos >= 5 && pos < 9) begin
            er = 1'b0;
            if (w[13:7] != ZP) begin
                ed = 2'b10;
                es = w[13:7];
            end
        end else if (pos == 9) begin
            ef = 1'b1;
        end
        chk_out($sformatf("%s_p%0d", tag, pos), es, ed, er, ef);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [13:0] w2, w3, w4, w5, model, word;
    logic [1:0]  prev_dig;
    logic        cap;
    logic [6:0]  es;

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b0;
        i_valid = 1'b0;
        i_seg   = '0;
        w2 = {7'b1111001, 7'b0010010};
        w3 = {ZP, 7'b0100100};
        w4 = {7'b0110000, 7'b0011001};
        w5 = {7'b0000010, 7'b1111000};

        #2 rst = 1'b1;
        #1 chk_dark("reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_dark("idle");
        end

        // "1","5": one-cycle valid in IDLE, two full frames
        i_valid = 1'b1;
        i_seg   = w2;
        step();
        i_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) step();
            chk_pos("w2", k % 10, w2);
        end

        // leading-zero high digit is blanked, frame timing unchanged
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
        i_valid = 1'b1;
        i_seg   = w3;
        step();
        i_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            chk_pos("w3", k, w3);
        end

        // valid held through SHOW_LO, captured only in GAP_LO
        step();
        i_valid = 1'b1;
        i_seg   = w4;
        chk_pos("hold", 0, w3);
        for (int k = 1; k < 5; k++) begin
            step();
            chk_pos("hold", k, w3);
        end
        step();
        i_valid = 1'b0;
        for (int k = 5; k < 10; k++) begin
            if (k > 5) step();
            chk_pos("w4", k, w4);
        end

        // transfer on the final GAP_HI cycle shows at next SHOW_LO
        i_valid = 1'b1;
        i_seg   = w5;
        step();
        i_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step();
            chk_pos("w5", k, w5);
        end

        // async reset during second SHOW_HI cycle
        rst = 1'b1;
        #1 chk_dark("arst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_dark("post_rst");
        end

        // randomized invariant run
        model    = {7'h7F, 7'h7F};
        prev_dig = 2'b00;
        for (int i = 0; i < 1000; i++) begin
            i_valid = ($urandom_range(0, 3) == 0);
            word[6:0]  = 7'($urandom);
            word[13:7] = ($urandom_range(0, 3) == 0) ? ZP : 7'($urandom);
            i_seg = word;
            cap   = i_valid && o_ready;
            step();
            if (cap) model = word;
            chk("rnd_onehot", 16'(o_dig == 2'b11), 16'(0));
            chk("rnd_gap", 16'(o_dig != 2'b00 && prev_dig != 2'b00 &&
                               o_dig != prev_dig), 16'(0));
            if (o_dig == 2'b01)
                es = model[6:0];
            else if (o_dig == 2'b10)
                es = model[13:7];
            else
                es = 7'h7F;
            chk("rnd_seg", 16'(o_seg), 16'(es));
            prev_dig = o_dig;
        end
        i_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
